// File: rtl/memory_pkg.sv
// Shared widths, beat count and state encoding for the block-transfer memory responder.
package memory_pkg;
  localparam int unsigned DATABUS_WIDTH = 32;
  localparam int unsigned BLOCK_WIDTH   = 256;
  localparam int unsigned BEATS         = BLOCK_WIDTH / DATABUS_WIDTH;
  localparam int unsigned ADDR_WIDTH    = 16;
  localparam int unsigned BEAT_CNT_W    = 3;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t READ  = 2'd1;
  localparam state_t WRITE = 2'd2;
endpackage

// File: rtl/block_ram.sv
// Single-port block storage with synchronous write and registered read data.
module block_ram #(
  parameter int unsigned depth = 256,
  parameter int unsigned width = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(depth)-1:0] addr,
  input  logic [width-1:0]         wdata,
  output logic [width-1:0]         rdata
);
  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/memory_responder.sv
// Memory responder: accepts block read/write requests and streams eight beats per block,
// most-significant word first.
module memory_responder
  import memory_pkg::*;
#(
  parameter int unsigned databusWidth       = DATABUS_WIDTH,
  parameter int unsigned blockWidth         = BLOCK_WIDTH,
  parameter int unsigned iMemoryAddressSize = ADDR_WIDTH,
  parameter int unsigned depthBlocks        = 256
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic [iMemoryAddressSize-1:0] address_i,
  input  logic                          isWrite_i,
  input  logic                          memoryMakeRequest_i,
  input  logic [databusWidth-1:0]       memoryDataBus_i,
  output logic [databusWidth-1:0]       memoryDataBus_o,
  output logic                          memEnable_o,
  output logic                          isBusy_o
);
  localparam int unsigned IDX_W = $clog2(depthBlocks);

  state_t                  state;
  logic [BEAT_CNT_W-1:0]   beat;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        ram_addr;
  logic                    ram_we;
  logic [blockWidth-1:0]   staging;
  logic [blockWidth-1:0]   wblock;
  logic [blockWidth-1:0]   ram_rdata;
  logic                    last_beat;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^address_i[iMemoryAddressSize-1:IDX_W];
  assign last_beat        = (beat == BEAT_CNT_W'(BEATS - 1));

  // While idle the RAM is addressed straight from the request so the registered
  // read data is already valid in the first beat cycle.
  assign ram_addr = (state == IDLE) ? address_i[IDX_W-1:0] : idx;
  assign ram_we   = (state == WRITE) && last_beat && !reset_i;

  // Beat k occupies word slot BEATS-1-k, so beat 0 is the most-significant word.
  always_comb begin
    wblock = staging;
    wblock[blockWidth-1-beat*databusWidth -: databusWidth] = memoryDataBus_i;
  end

  block_ram #(
    .depth (depthBlocks),
    .width (blockWidth)
  ) u_ram (
    .clk   (clock_i),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wblock),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memoryMakeRequest_i) begin
            idx   <= address_i[IDX_W-1:0];
            beat  <= '0;
            state <= isWrite_i ? WRITE : READ;
          end
        end
        READ, WRITE: begin
          if (state == WRITE) staging <= wblock;
          if (last_beat) begin
            state <= IDLE;
            beat  <= '0;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          beat  <= '0;
        end
      endcase
    end
  end

  assign memEnable_o     = (state == READ) || (state == WRITE);
  assign isBusy_o        = memEnable_o;
  assign memoryDataBus_o = (state == READ)
                         ? ram_rdata[blockWidth-1-beat*databusWidth -: databusWidth]
                         : '0;
endmodule

// File: tb/tb_memory_responder.sv
// Directed self-checking bench for memory_responder.
module tb_memory_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = '0;
  logic        wr = 1'b0;
  logic        req = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        en;
  logic        busy;

  int checks = 0;
  int errors = 0;

  memory_responder #(
    .databusWidth       (32),
    .blockWidth         (256),
    .iMemoryAddressSize (16),
    .depthBlocks        (256)
  ) dut (
    .clock_i             (clk),
    .reset_i             (rst),
    .address_i           (addr),
    .isWrite_i           (wr),
    .memoryMakeRequest_i (req),
    .memoryDataBus_i     (din),
    .memoryDataBus_o     (dout),
    .memEnable_o         (en),
    .isBusy_o            (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_en"},   {31'd0, en},   32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_dout"}, dout,          32'd0);
  endtask

  task automatic request(input logic [15:0] a, input logic w);
    addr = a; wr = w; req = 1'b1;
    tick();
    req = 1'b0; wr = 1'b0; addr = '0;
  endtask

  task automatic write_block(input logic [15:0] a, input logic [31:0] base, input logic [31:0] step);
    request(a, 1'b1);
    for (int k = 0; k < 8; k++) begin
      din = base + step * k;
      check($sformatf("wr%0h_en%0d", a, k),   {31'd0, en},   32'd1);
      check($sformatf("wr%0h_busy%0d", a, k), {31'd0, busy}, 32'd1);
      check($sformatf("wr%0h_dout%0d", a, k), dout,          32'd0);
      tick();
    end
    din = '0;
    check_idle($sformatf("wr%0h_done", a));
  endtask

  task automatic read_block(input logic [15:0] a, input logic [31:0] base, input logic [31:0] step,
                            input logic inject);
    request(a, 1'b0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rd%0h_en%0d", a, k),   {31'd0, en},   32'd1);
      check($sformatf("rd%0h_busy%0d", a, k), {31'd0, busy}, 32'd1);
      check($sformatf("rd%0h_beat%0d", a, k), dout,          base + step * k);
      if (inject && k == 3) begin
        addr = 16'h0010; wr = 1'b1; req = 1'b1;
      end
      tick();
      req = 1'b0; wr = 1'b0; addr = '0;
    end
    check_idle($sformatf("rd%0h_done", a));
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    check_idle("reset");
    rst = 1'b0;
    tick();
    check_idle("post_reset");

    write_block(16'h0005, 32'h88888888, 32'h11111111);
    read_block(16'h0005, 32'h88888888, 32'h11111111, 1'b0);
    read_block(16'h0105, 32'h88888888, 32'h11111111, 1'b0);

    // Request during beat 3 must be ignored: no second transfer afterwards.
    read_block(16'h0005, 32'h88888888, 32'h11111111, 1'b1);
    tick();
    check_idle("ignored_req_a");
    tick();
    check_idle("ignored_req_b");

    // Known contents at 0x0007, then an interrupted overwrite.
    write_block(16'h0007, 32'h70000000, 32'h00000001);
    request(16'h0007, 1'b1);
    for (int k = 0; k < 5; k++) begin
      din = 32'hAAAAAAAA;
      check($sformatf("wr_int_en%0d", k), {31'd0, en}, 32'd1);
      if (k == 4) rst = 1'b1;
      tick();
    end
    rst = 1'b0; din = '0;
    check_idle("after_int_reset");
    read_block(16'h0007, 32'h70000000, 32'h00000001, 1'b0);

    // Reset wins over a simultaneous request.
    rst = 1'b1; addr = 16'h0005; wr = 1'b0; req = 1'b1;
    tick();
    rst = 1'b0; req = 1'b0; addr = '0;
    check_idle("rst_req_a");
    tick();
    check_idle("rst_req_b");

    read_block(16'h0005, 32'h88888888, 32'h11111111, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
